pito_hart_scheduler: RTL and testbench
======================================

// Module: pito_hart_scheduler
// PURPOSE
//  Barrel-thread issue scheduler for the pito RV32 core. Keeps one PC per hart and picks
//  one ready hart per fetch slot, round-robin. A hart is blocked while its instruction is
//  in flight and resumes when the pipeline writes back its next PC. WFI parks a hart until
//  its wake line rises. Sits between the pipeline writeback stage and instruction fetch.
// PARAMETERS
//  NUM_HARTS  8   number of harts (power of two, 2..32)
//  HART_W     3   hart id width, $clog2(NUM_HARTS)
//  XPR_LEN    32  PC width
//  RESET_PC   0   PC loaded into every hart at reset
// PORTS
//  clk          in   1          core clock
//  rst_n        in   1          asynchronous, active-low reset
//  hart_en      in   NUM_HARTS  per-hart run enable
//  issue_valid  out  1          fetch slot carries a hart
//  issue_ready  in   1          fetch accepts slot (imem not stalled)
//  issue_hart   out  HART_W     hart id of slot
//  issue_pc     out  XPR_LEN    PC to fetch for issue_hart
//  pc_wr_valid  in   1          pipeline returns next PC of a retired instruction
//  pc_wr_hart   in   HART_W     hart id of returned PC
//  pc_wr_pc     in   XPR_LEN    next PC (bits[1:0] discarded, stored as 0)
//  wfi_valid    in   1          qualifies pc_wr: retired instr was WFI
//  wake         in   NUM_HARTS  per-hart wake (interrupt pending), level
//  hart_sleep   out  NUM_HARTS  hart is in SLEEP
//  sched_err    out  1          sticky: pc_wr to a hart not INFLIGHT
// BEHAVIOUR
//  - Per-hart state: IDLE, READY, INFLIGHT, SLEEP; per-hart PC register.
//  - Reset: every hart IDLE, PC=RESET_PC; issue_valid=0, issue_hart=0, issue_pc=0,
//    hart_sleep=0, sched_err=0; RR pointer=NUM_HARTS-1 (hart 0 wins first).
//  - IDLE->READY when hart_en[h]=1; READY->IDLE when hart_en[h]=0.
//  - INFLIGHT ignores hart_en; on pc_wr it goes to READY (or IDLE if hart_en[h]=0);
//    stored PC kept, so re-enable resumes at that PC.
//  - Selection: first READY hart scanning ptr+1, ptr+2, ... with wrap modulo NUM_HARTS.
//  - Issue outputs registered: hart READY in cycle N may appear on issue in N+1 at earliest.
//  - Handshake: issue_valid&issue_ready fires; hart->INFLIGHT, ptr=issue_hart. While
//    issue_valid&!issue_ready, valid/hart/pc held stable, no re-arbitration.
//  - After fire, next slot presented the following cycle (back-to-back issue, 1 slot/clk).
//  - No READY hart: issue_valid=0; issue_hart/issue_pc hold last value.
//  - pc_wr_valid: if hart INFLIGHT, PC<=pc_wr_pc&~3; else ignored, sched_err<=1 (sticky
//    until reset). Ignored write changes no state.
//  - pc_wr of hart h and issue of h never coincide (h is INFLIGHT while issued).
//  - WFI (pc_wr_valid&wfi_valid): PC stored as above; hart->SLEEP unless wake[h]=1 that
//    same cycle, then READY (wake never lost). SLEEP->READY on wake[h]=1 (next-cycle elig.).
//  - hart_en[h]=0 while SLEEP: SLEEP->IDLE. hart_sleep[h]=(state==SLEEP), registered.
//  - Reset asserted mid-operation: all state, PCs and outputs return to reset values
//    asynchronously; in-flight writebacks after reset count as errors.
// CONFIGURATION
//  PITO_HART_WFI_EN defined: WFI/SLEEP/wake behaviour as above.
//  Not defined: wfi_valid and wake ignored, pc_wr with wfi_valid treated as normal pc_wr,
//  SLEEP state not built, hart_sleep tied to 0. Ports present in both builds.
// TESTING
//  1 Reset, hart_en=8'hFF, issue_ready=1, each pc_wr returned 4 clk after issue with
//    pc+4 -> issue order 0..7 then 0, first pass pc=0x0, second pass pc=0x4.
//  2 issue_ready=0 for 3 clk while slot shows hart2 pc=0x40 -> slot stable 3 clk; after
//    fire, next slot hart3.
//  3 (WFI_EN) pc_wr hart1 pc=0x106 wfi_valid=1 -> hart_sleep=8'h02, hart1 skipped;
//    wake[1]=1 -> hart1 issued with pc=0x104.
//  4 (WFI_EN) WFI writeback hart4 with wake[4]=1 same clk -> hart_sleep[4]=0, hart4 reissued.
//  5 pc_wr_valid to READY hart6 pc=0x80 -> PC unchanged, sched_err=1 until rst_n low.
//  6 hart_en[5]=0 while hart5 INFLIGHT; pc_wr 0x200 -> hart5 not issued; hart_en[5]=1
//    -> hart5 issued with pc=0x200.

Source files
------------

// File: rtl/pito_hart_scheduler.sv
// -----------------------------------------------------------------------------
// pito_hart_scheduler
//
// Barrel-thread issue scheduler for the pito RV32 core. One PC register and one
// small state machine per hart. Every fetch slot it offers one READY hart,
// chosen round-robin, to instruction fetch. A hart that has been issued stays
// INFLIGHT until the pipeline writes back its next PC. With PITO_HART_WFI_EN
// defined, a WFI writeback parks the hart in SLEEP until its wake line rises.
//
// Optional feature macro: PITO_HART_WFI_EN
//   defined     : WFI / SLEEP / wake behaviour built.
//   not defined : wfi_valid and wake ignored, hart_sleep tied to 0.
//
// Ports
//   clk          in   core clock
//   rst_n        in   asynchronous active-low reset
//   hart_en      in   [NUM_HARTS] per-hart run enable
//   issue_valid  out  fetch slot carries a hart
//   issue_ready  in   fetch accepts the slot this cycle
//   issue_hart   out  [HART_W] hart id of the slot
//   issue_pc     out  [XPR_LEN] PC to fetch for issue_hart
//   pc_wr_valid  in   pipeline returns the next PC of a retired instruction
//   pc_wr_hart   in   [HART_W] hart of the returned PC
//   pc_wr_pc     in   [XPR_LEN] next PC (bits [1:0] stored as zero)
//   wfi_valid    in   qualifies pc_wr: the retired instruction was WFI
//   wake         in   [NUM_HARTS] per-hart wake request (level)
//   hart_sleep   out  [NUM_HARTS] hart is parked in SLEEP
//   sched_err    out  sticky: a PC writeback hit a hart that was not INFLIGHT
// -----------------------------------------------------------------------------
module pito_hart_scheduler #(
  parameter int                 NUM_HARTS = 8,
  parameter int                 HART_W    = 3,
  parameter int                 XPR_LEN   = 32,
  parameter logic [XPR_LEN-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_HARTS-1:0] hart_en,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [HART_W-1:0]    issue_hart,
  output logic [XPR_LEN-1:0]   issue_pc,
  input  logic                 pc_wr_valid,
  input  logic [HART_W-1:0]    pc_wr_hart,
  input  logic [XPR_LEN-1:0]   pc_wr_pc,
  input  logic                 wfi_valid,
  input  logic [NUM_HARTS-1:0] wake,
  output logic [NUM_HARTS-1:0] hart_sleep,
  output logic                 sched_err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_READY    = 2'd1;
  localparam logic [1:0] ST_INFLIGHT = 2'd2;
`ifdef PITO_HART_WFI_EN
  localparam logic [1:0] ST_SLEEP    = 2'd3;
`endif

  logic [1:0]           state     [NUM_HARTS];
  logic [1:0]           state_nxt [NUM_HARTS];
  logic [XPR_LEN-1:0]   pc_q      [NUM_HARTS];
  logic [HART_W-1:0]    ptr;

  logic                 fire;
  logic                 hold;
  logic                 wr_hit;
  logic [XPR_LEN-1:0]   wr_pc;
  logic [NUM_HARTS-1:0] ready_mask;
  logic [NUM_HARTS-1:0] fire_mask;
  logic [NUM_HARTS-1:0] elig;
  logic [HART_W-1:0]    scan_base;
  logic [HART_W-1:0]    pick_hart;
  logic                 pick_found;

  assign fire = issue_valid & issue_ready;
  // A presented but unaccepted slot is frozen: no re-arbitration.
  assign hold = issue_valid & ~issue_ready;

  // Only an INFLIGHT hart may take a writeback; anything else is dropped
  // and flagged.
  assign wr_hit = pc_wr_valid && (state[pc_wr_hart] == ST_INFLIGHT);
  assign wr_pc  = pc_wr_pc & ~(XPR_LEN'(3));

`ifndef PITO_HART_WFI_EN
  logic unused_wfi;
  assign unused_wfi = wfi_valid ^ (^wake);
`endif

  // Per-hart state transitions
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      state_nxt[h] = state[h];
      case (state[h])
        ST_IDLE: begin
          if (hart_en[h]) state_nxt[h] = ST_READY;
        end
        ST_READY: begin
          // The hart sitting in a valid slot is pinned until the slot resolves,
          // so a stalled slot never advertises a hart that has gone IDLE.
          if (fire && (issue_hart == HART_W'(h)))
            state_nxt[h] = ST_INFLIGHT;
          else if (!hart_en[h] && !(issue_valid && (issue_hart == HART_W'(h))))
            state_nxt[h] = ST_IDLE;
        end
        ST_INFLIGHT: begin
          if (wr_hit && (pc_wr_hart == HART_W'(h))) begin
            if (!hart_en[h])
              state_nxt[h] = ST_IDLE;
`ifdef PITO_HART_WFI_EN
            // A wake already pending in the writeback cycle skips SLEEP.
            else if (wfi_valid && !wake[h])
              state_nxt[h] = ST_SLEEP;
`endif
            else
              state_nxt[h] = ST_READY;
          end
        end
`ifdef PITO_HART_WFI_EN
        ST_SLEEP: begin
          if (!hart_en[h])
            state_nxt[h] = ST_IDLE;
          else if (wake[h])
            state_nxt[h] = ST_READY;
        end
`endif
        default: state_nxt[h] = ST_IDLE;
      endcase
    end
  end

  // Round-robin pick
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      ready_mask[h] = (state[h] == ST_READY);
    end
  end

  // On a fire the issued hart is leaving READY and the pointer moves to it,
  // so the next slot is chosen relative to issue_hart in the same cycle.
  assign fire_mask = fire ? (NUM_HARTS'(1) << issue_hart) : '0;
  assign elig      = ready_mask & ~fire_mask;
  assign scan_base = fire ? issue_hart : ptr;

  always_comb begin
    logic [HART_W-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_hart  = '0;
    // Walk from the farthest candidate to the nearest so the nearest eligible
    // hart (base+1) is the last one written and therefore wins.
    for (int i = NUM_HARTS; i >= 1; i--) begin
      cand = scan_base + HART_W'(i);
      if (elig[cand]) begin
        pick_found = 1'b1;
        pick_hart  = cand;
      end
    end
  end

  // Registered state, PCs and issue slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        state[h] <= ST_IDLE;
        pc_q[h]  <= RESET_PC;
      end
      ptr         <= HART_W'(NUM_HARTS - 1);
      issue_valid <= 1'b0;
      issue_hart  <= '0;
      issue_pc    <= '0;
      sched_err   <= 1'b0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        state[h] <= state_nxt[h];
      end
      if (wr_hit) pc_q[pc_wr_hart] <= wr_pc;
      if (pc_wr_valid && !wr_hit) sched_err <= 1'b1;
      if (fire) ptr <= issue_hart;
      if (!hold) begin
        // With nothing READY the id/pc keep their last value.
        issue_valid <= pick_found;
        if (pick_found) begin
          issue_hart <= pick_hart;
          issue_pc   <= pc_q[pick_hart];
        end
      end
    end
  end

`ifdef PITO_HART_WFI_EN
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      hart_sleep[h] = (state[h] == ST_SLEEP);
    end
  end
`else
  assign hart_sleep = '0;
`endif

endmodule

// File: tb/tb_pito_hart_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for pito_hart_scheduler. A behavioural scheduler model runs on the
// clock and every output is compared against it each cycle; directed scenarios
// add literal expectations on the issue order and PCs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pito_hart_scheduler;
  localparam int N  = 8;
  localparam int HW = 3;
`ifdef PITO_HART_WFI_EN
  localparam bit WFI = 1'b1;
`else
  localparam bit WFI = 1'b0;
`endif
  localparam int M_IDLE = 0, M_READY = 1, M_BUSY = 2, M_SLEEP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  hart_en = '0;
  logic [N-1:0]  wake = '0;
  logic          issue_ready = 1'b0;
  logic          issue_valid;
  logic [HW-1:0] issue_hart;
  logic [31:0]   issue_pc;
  logic          pc_wr_valid = 1'b0;
  logic [HW-1:0] pc_wr_hart = '0;
  logic [31:0]   pc_wr_pc = '0;
  logic          wfi_valid = 1'b0;
  logic [N-1:0]  hart_sleep;
  logic          sched_err;

  pito_hart_scheduler #(.NUM_HARTS(N), .HART_W(HW), .XPR_LEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .hart_en(hart_en),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_hart(issue_hart), .issue_pc(issue_pc),
    .pc_wr_valid(pc_wr_valid), .pc_wr_hart(pc_wr_hart), .pc_wr_pc(pc_wr_pc),
    .wfi_valid(wfi_valid), .wake(wake),
    .hart_sleep(hart_sleep), .sched_err(sched_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  logic [N-1:0] auto_mask = '0;

  typedef struct { int due; int hart; logic [31:0] pc; bit wfi; } wb_t;
  typedef struct { int hart; logic [31:0] pc; } iss_t;
  wb_t  wq[$];
  iss_t ilog[$];

  // behavioural model
  int          m_st[N];
  logic [31:0] m_pc[N];
  int          m_ptr;
  bit          m_valid;
  int          m_hart;
  logic [31:0] m_ipc;
  bit          m_err;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < N; h++) begin m_st[h] = M_IDLE; m_pc[h] = 32'h0; end
    m_ptr = N - 1; m_valid = 0; m_hart = 0; m_ipc = 32'h0; m_err = 0;
  endtask

  task automatic model_step();
    int st0[N];
    bit fire, hold;
    int fh, base, h;
    logic [31:0] fpc;
    fire = m_valid && issue_ready;
    hold = m_valid && !issue_ready;
    fh = m_hart; fpc = m_ipc;
    st0 = m_st;
    for (int k = 0; k < N; k++) begin
      if (st0[k] == M_IDLE && hart_en[k]) m_st[k] = M_READY;
      else if (st0[k] == M_READY) begin
        if (fire && k == fh) m_st[k] = M_BUSY;
        else if (!hart_en[k] && !(m_valid && k == m_hart)) m_st[k] = M_IDLE;
      end else if (st0[k] == M_SLEEP) begin
        if (!hart_en[k]) m_st[k] = M_IDLE;
        else if (wake[k]) m_st[k] = M_READY;
      end
    end
    if (pc_wr_valid) begin
      h = int'(pc_wr_hart);
      if (st0[h] != M_BUSY) m_err = 1;
      else begin
        m_pc[h] = {pc_wr_pc[31:2], 2'b00};
        if (!hart_en[h]) m_st[h] = M_IDLE;
        else if (WFI && wfi_valid && !wake[h]) m_st[h] = M_SLEEP;
        else m_st[h] = M_READY;
      end
    end
    if (fire && auto_mask[fh]) wq.push_back('{cyc + 4, fh, fpc + 32'd4, 1'b0});
    if (!hold) begin
      base = fire ? fh : m_ptr;
      if (fire) m_ptr = fh;
      m_valid = 0;
      for (int k = 1; k <= N; k++) begin
        h = (base + k) % N;
        if (!m_valid && st0[h] == M_READY && !(fire && h == fh)) begin
          m_valid = 1; m_hart = h; m_ipc = m_pc[h];
        end
      end
    end
  endtask

  // Model advance and DUT issue log on the active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      cyc++;
      if (issue_valid && issue_ready) ilog.push_back('{int'(issue_hart), issue_pc});
      model_step();
    end
  end

  // Writeback driver: one queued entry per cycle once it falls due.
  always @(negedge clk) begin
    int idx;
    idx = -1;
    for (int i = 0; i < wq.size(); i++) if (idx < 0 && wq[i].due <= cyc + 1) idx = i;
    if (idx >= 0) begin
      pc_wr_valid = 1'b1; pc_wr_hart = HW'(wq[idx].hart);
      pc_wr_pc = wq[idx].pc; wfi_valid = wq[idx].wfi;
      wq.delete(idx);
    end else begin
      pc_wr_valid = 1'b0; wfi_valid = 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [N-1:0] msl;
    if (chk_en) begin
      for (int h = 0; h < N; h++) msl[h] = (m_st[h] == M_SLEEP);
      check("issue_valid", issue_valid, m_valid);
      check("issue_hart", issue_hart, m_hart);
      check("issue_pc", issue_pc, m_ipc);
      check("hart_sleep", hart_sleep, msl);
      check("sched_err", sched_err, m_err);
    end
  end

  task automatic push_wb(input int h, input logic [31:0] pc, input bit w);
    wq.push_back('{cyc + 2, h, pc, w});
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    wq.delete();
    #2 rst_n = 1'b0;
    #1;
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_hart", issue_hart, 0);
    check("rst_issue_pc", issue_pc, 0);
    check("rst_hart_sleep", hart_sleep, 0);
    check("rst_sched_err", sched_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int t;
    t = 0;
    while (ilog.size() < n && t < budget) begin @(negedge clk); t++; end
    if (ilog.size() < n) begin
      n_checks++; n_err++;
      $display("FAIL %s: timeout, %0d issues seen, %0d required", nm, ilog.size(), n);
    end
  endtask

  task automatic log_chk(input int idx, input int h, input logic [31:0] pc, input string nm);
    if (idx < 0 || idx >= ilog.size()) begin
      n_checks++; n_err++;
      $display("FAIL %s: no issue recorded at index %0d, expected hart %0d", nm, idx, h);
    end else begin
      check({nm, "_hart"}, ilog[idx].hart, h);
      check({nm, "_pc"}, ilog[idx].pc, pc);
    end
  endtask

  initial begin
    int base, cnt, first;
    chk_en = 1'b1;

    // 1: round-robin with 4-cycle writeback latency
    hart_en = '0; issue_ready = 1'b1; auto_mask = 8'hFF;
    do_reset();
    base = ilog.size();
    hart_en = 8'hFF;
    wait_log(base + 9, 40, "t1_wait");
    for (int i = 0; i < 9; i++) log_chk(base + i, i % 8, (i < 8) ? 32'h0 : 32'h4, "t1_order");

    // 2: stalled slot holds, next slot follows
    hart_en = 8'h04; auto_mask = '0;
    do_reset();
    base = ilog.size();
    wait_log(base + 1, 10, "t2_wait");
    log_chk(base, 2, 32'h0, "t2_first");
    issue_ready = 1'b0;
    push_wb(2, 32'h40, 1'b0);
    repeat (3) @(negedge clk);
    hart_en = 8'h0C;
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_valid", issue_valid, 1);
      check("t2_hold_hart", issue_hart, 2);
      check("t2_hold_pc", issue_pc, 32'h40);
      @(negedge clk);
    end
    issue_ready = 1'b1;
    @(negedge clk);
    log_chk(ilog.size() - 1, 2, 32'h40, "t2_fire");
    check("t2_next_valid", issue_valid, 1);
    check("t2_next_hart", issue_hart, 3);

    // 3: WFI parks hart1 until wake (ignored when the feature is absent)
    issue_ready = 1'b1; hart_en = 8'h03; auto_mask = 8'hFD;
    do_reset();
    base = ilog.size();
    wait_log(base + 2, 10, "t3_wait");
    log_chk(base, 0, 32'h0, "t3_h0");
    log_chk(base + 1, 1, 32'h0, "t3_h1");
    push_wb(1, 32'h106, 1'b1);
    repeat (6) @(negedge clk);
    check("t3_sleep", hart_sleep, WFI ? 8'h02 : 8'h00);
    cnt = 0;
    for (int i = base + 2; i < ilog.size(); i++) if (ilog[i].hart == 1) cnt++;
    check("t3_skipped", cnt, WFI ? 0 : 1);
    wake = 8'h02;
    @(negedge clk);
    wake = '0;
    repeat (5) @(negedge clk);
    first = -1;
    for (int i = base + 2; i < ilog.size(); i++) if (first < 0 && ilog[i].hart == 1) first = i;
    log_chk(first, 1, 32'h104, "t3_wake");
    check("t3_sleep_clr", hart_sleep, 0);

    // 4: WFI writeback with wake already high does not sleep
    hart_en = 8'h10; auto_mask = '0;
    do_reset();
    base = ilog.size();
    wait_log(base + 1, 10, "t4_wait");
    log_chk(base, 4, 32'h0, "t4_first");
    push_wb(4, 32'h300, 1'b1);
    @(negedge clk);
    wake = 8'h10;
    @(negedge clk);
    wake = '0;
    check("t4_sleep", hart_sleep, 0);
    wait_log(base + 2, 10, "t4_wait2");
    log_chk(base + 1, 4, 32'h300, "t4_reissue");
    check("t4_sleep2", hart_sleep, 0);

    // 5: writeback to a READY hart is dropped and flagged
    hart_en = 8'h40; issue_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    check("t5_slot_valid", issue_valid, 1);
    check("t5_slot_hart", issue_hart, 6);
    check("t5_err0", sched_err, 0);
    push_wb(6, 32'h80, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_err1", sched_err, 1);
    check("t5_slot_pc", issue_pc, 32'h0);
    issue_ready = 1'b1;
    base = ilog.size();
    wait_log(base + 1, 10, "t5_wait");
    log_chk(base, 6, 32'h0, "t5_pc_kept");
    repeat (4) @(negedge clk);
    check("t5_err_sticky", sched_err, 1);

    // 6: disable while INFLIGHT, resume at the written-back PC
    hart_en = 8'h20; issue_ready = 1'b1;
    do_reset();
    base = ilog.size();
    wait_log(base + 1, 10, "t6_wait");
    log_chk(base, 5, 32'h0, "t6_first");
    hart_en = '0;
    push_wb(5, 32'h200, 1'b0);
    repeat (5) @(negedge clk);
    check("t6_not_issued", ilog.size(), base + 1);
    check("t6_idle_valid", issue_valid, 0);
    hart_en = 8'h20;
    wait_log(base + 2, 10, "t6_wait2");
    log_chk(base + 1, 5, 32'h200, "t6_resume");

    // 7: writeback for an instruction in flight across a reset is an error
    hart_en = 8'h01;
    do_reset();
    base = ilog.size();
    wait_log(base + 1, 10, "t7_wait");
    hart_en = '0;
    do_reset();
    push_wb(0, 32'h10, 1'b0);
    repeat (3) @(negedge clk);
    check("t7_err", sched_err, 1);
    check("t7_valid", issue_valid, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
